half_adder_tester: RTL and testbench

- Board-level self-test initiator for the half-adder datapath.
- Drives the adder's a/b inputs through all four vectors, samples s/carry after a settle window and compares against expected values.
- Reports pass/fail and per-vector failures on LEDs.
- Started by a debounced push-button; sits beside the half-adder on the board top level, replacing the switches as stimulus source.

---
 rtl/half_adder_tester.sv | 136 +++++++++++++
 tb/tb_half_adder_tester.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/half_adder_tester.sv
// rtl/half_adder_tester.sv - button-started self-test initiator for a half-adder
module half_adder_tester #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       dut_s,
  input  logic       dut_carry,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

  logic          sync1, sync2, deb_level, deb_prev;
  logic [DW-1:0] deb_cnt;
  logic          start_pulse;

  state_t        state, state_next;
  logic [1:0]    idx, idx_next;
  logic [SW-1:0] settle_cnt, settle_next;
  logic [2:0]    err_next;
  logic [3:0]    mask_next;
  logic          mismatch;

  // Synchronize the raw button and accept a new level only after it has been stable long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync1    <= btn_start;
      sync2    <= sync1;
      deb_prev <= deb_level;
      if (sync2 != deb_level) begin
        if (deb_cnt == DEB_LAST) begin
          deb_level <= sync2;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign start_pulse = deb_level & ~deb_prev;

  // A vector fails if either the sum or the carry disagrees with the truth table
  assign mismatch = (dut_s != (idx[0] ^ idx[1])) || (dut_carry != (idx[0] & idx[1]));

  // Test sequencer state and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      settle_cnt <= '0;
      err_count  <= 3'd0;
      fail_mask  <= 4'd0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      settle_cnt <= settle_next;
      err_count  <= err_next;
      fail_mask  <= mask_next;
    end
  end

  // Next-state logic: walk the four vectors, sampling the adder only in CHECK
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    settle_next = settle_cnt;
    err_next    = err_count;
    mask_next   = fail_mask;
    case (state)
      IDLE, DONE: begin
        if (start_pulse) begin
          state_next = APPLY;
          idx_next   = 2'd0;
          err_next   = 3'd0;
          mask_next  = 4'd0;
        end
      end
      APPLY: begin
        settle_next = SETTLE_LOAD;
        state_next  = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          state_next = CHECK;
        end else begin
          settle_next = settle_cnt - SW'(1);
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_next  = err_count + 3'd1;
          mask_next = fail_mask | (4'b0001 << idx);
        end
        if (idx == 2'd3) begin
          state_next = DONE;
        end else begin
          idx_next   = idx + 2'd1;
          state_next = APPLY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy  = (state == APPLY) || (state == SETTLE) || (state == CHECK);
  assign dut_a = busy & idx[0];
  assign dut_b = busy & idx[1];
  assign done  = (state == DONE);
  assign pass  = done & (err_count == 3'd0);
  assign fail  = done & (err_count != 3'd0);

endmodule

// File: tb/tb_half_adder_tester.sv
// tb/tb_half_adder_tester.sv - scoreboard bench for half_adder_tester
module tb_half_adder_tester;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       dut_s, dut_carry, dut_a, dut_b;
  logic       busy, done, pass, fail;
  logic [2:0] err_count;
  logic [3:0] fail_mask;
  int         fault_mode = 0;

  int n_checks = 0;
  int n_fails  = 0;
  int runs_seen = 0;
  int busy_cyc = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  // Half-adder model with optional planted faults: 1 = carry stuck at 0, 2 = sum inverted
  assign dut_s     = (dut_a ^ dut_b) ^ (fault_mode == 2);
  assign dut_carry = (dut_a & dut_b) & (fault_mode != 1);

  half_adder_tester #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start),
    .dut_s(dut_s), .dut_carry(dut_carry),
    .dut_a(dut_a), .dut_b(dut_b), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .err_count(err_count), .fail_mask(fail_mask)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: checks vector sequence during a run, run length and results when done rises
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (!prev_busy) runs_seen++;
      check("vector", {30'd0, dut_b, dut_a}, 32'(busy_cyc / 4));
      busy_cyc++;
    end else begin
      if (done === 1'b1 && !prev_done) begin
        check("busy_len", busy_cyc, 16);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          logic [6:0] e;
          e = exp_q.pop_front();
          check("err_count", err_count, e[6:4]);
          check("fail_mask", fail_mask, e[3:0]);
          check("pass", pass, e[6:4] == 3'd0);
          check("fail", fail, e[6:4] != 3'd0);
        end
      end
      busy_cyc = 0;
    end
    prev_busy = (busy === 1'b1);
    prev_done = (done === 1'b1);
  end

  task automatic check_all_zero(input string name);
    check(name, {19'd0, dut_a, dut_b, busy, done, pass, fail, err_count, fail_mask}, 0);
  endtask

  task automatic wait_busy(output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b1) ok = 1;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1;
    end
  endtask

  task automatic run_test(input int m, input logic [2:0] e_err, input logic [3:0] e_mask);
    bit ok;
    int base;
    fault_mode = m;
    exp_q.push_back({e_err, e_mask});
    base = runs_seen;
    btn_start = 1'b1;
    wait_busy(ok);
    check("start_timeout", ok, 1);
    check("cleared_on_start", {27'd0, done, pass, fail, err_count == 3'd0, fail_mask == 4'd0}, 3);
    repeat (3) @(negedge clk);
    btn_start = 1'b0;
    wait_done(ok);
    check("done_timeout", ok, 1);
    repeat (20) @(negedge clk);
    check("one_run", runs_seen - base, 1);
    check("done_held", done, 1);
  endtask

  initial begin
    bit ok;
    int base;
    // Reset with random button activity
    for (int i = 0; i < 3; i++) begin
      btn_start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check_all_zero("reset_outputs");
    btn_start = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_all_zero("idle_outputs");
    check("idle_no_run", runs_seen, 0);

    // Good adder, then carry stuck-at-0, then inverted sum (each press lands in DONE)
    run_test(0, 3'd0, 4'b0000);
    run_test(1, 3'd1, 4'b1000);
    run_test(2, 3'd4, 4'b1111);

    // Bouncing button must never start a run
    base = runs_seen;
    for (int i = 0; i < 15; i++) begin
      btn_start = ~btn_start;
      repeat (2) @(negedge clk);
    end
    btn_start = 1'b0;
    repeat (20) @(negedge clk);
    check("bounce_no_run", runs_seen - base, 0);
    check("bounce_busy", busy, 0);

    // Second press while busy is ignored
    fault_mode = 0;
    base = runs_seen;
    exp_q.push_back({3'd0, 4'b0000});
    btn_start = 1'b1;
    wait_busy(ok);
    check("start2_timeout", ok, 1);
    @(negedge clk);
    btn_start = 1'b0;
    repeat (6) @(negedge clk);
    btn_start = 1'b1;
    repeat (6) @(negedge clk);
    btn_start = 1'b0;
    wait_done(ok);
    check("done2_timeout", ok, 1);
    repeat (20) @(negedge clk);
    check("press_in_busy_runs", runs_seen - base, 1);

    // Reset while vector 2 is settling aborts the run
    btn_start = 1'b1;
    wait_busy(ok);
    check("start3_timeout", ok, 1);
    btn_start = 1'b0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if ({dut_b, dut_a} == 2'b10) ok = 1;
    end
    check("vec2_timeout", ok, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort_outputs");
    rst = 1'b0;
    base = runs_seen;
    repeat (30) @(negedge clk);
    check_all_zero("after_abort");
    check("after_abort_no_run", runs_seen - base, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
